// File: rtl/npc_codec_pkg.sv
// -----------------------------------------------------------------------------
// npc_codec_pkg
// Shared definitions for the priority-encoder / one-hot player codec path.
// Both the encoder side and the player side import this package.
//   CODE_W   : width of a binary code (3 -> codes 0..7)
//   ONEHOT_W : width of the decoded one-hot display (8)
//   play_state_e : playback FSM states
//   onehot_decode : binary code -> one-hot byte
// -----------------------------------------------------------------------------
package npc_codec_pkg;

   localparam int CODE_W   = 3;
   localparam int ONEHOT_W = 8;

   typedef enum logic {
      IDLE = 1'b0,
      SHOW = 1'b1
   } play_state_e;

   function automatic logic [ONEHOT_W-1:0] onehot_decode(input logic [CODE_W-1:0] code);
      logic [ONEHOT_W-1:0] res;
      res = '0;
      res[code] = 1'b1;
      return res;
   endfunction

endpackage

// File: rtl/code_fifo.sv
// -----------------------------------------------------------------------------
// code_fifo
// Synchronous FIFO, power-of-two depth, first-word-fall-through read port
// (dout always shows the head entry).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous flush, wins over push and pop
//   push, din  : write request / data (ignored when full)
//   pop        : read request (ignored when empty)
//   dout       : head entry
//   count      : occupancy 0..DEPTH
//   full/empty : occupancy flags
// -----------------------------------------------------------------------------
module code_fifo #(
   parameter int W     = 3,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     push,
   input  logic [W-1:0]             din,
   input  logic                     pop,
   output logic [W-1:0]             dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full && !clr;
   assign do_pop  = pop && !empty && !clr;
   assign dout    = mem_q[rd_ptr_q];
   assign count   = count_q;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is data only; occupancy tracking makes stale entries harmless.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/code_onehot_player.sv
// -----------------------------------------------------------------------------
// code_onehot_player
// Sequenced 3-to-8 decoder. Queues incoming codes in a FIFO and plays each
// one back as a registered one-hot byte for HOLD enabled cycles.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous flush of FIFO and playback
//   en         : hold-counter tick; playback freezes while low
//   in_valid/in_ready/in_code : code input handshake (in_ready = !full)
//   out        : registered one-hot display, 8'h00 when idle
//   out_valid  : high while a code is displayed
//   count      : FIFO occupancy
// -----------------------------------------------------------------------------
module code_onehot_player
   import npc_codec_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int HOLD  = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     en,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [CODE_W-1:0]        in_code,
   output logic [ONEHOT_W-1:0]      out,
   output logic                     out_valid,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int HC_W = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [HC_W-1:0] HOLD_RELOAD = HC_W'(HOLD - 1);

   play_state_e         state_q, state_d;
   logic [HC_W-1:0]     hold_q, hold_d;
   logic [ONEHOT_W-1:0] out_q, out_d;
   logic                vld_q, vld_d;

   logic                fifo_full;
   logic                fifo_empty;
   logic                fifo_pop;
   logic [CODE_W-1:0]   fifo_head;

   code_fifo #(
      .W     (CODE_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .push  (in_valid && in_ready),
      .din   (in_code),
      .pop   (fifo_pop),
      .dout  (fifo_head),
      .count (count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign in_ready  = !fifo_full;
   assign out       = out_q;
   assign out_valid = vld_q;

   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      out_d    = out_q;
      vld_d    = vld_q;
      fifo_pop = 1'b0;
      if (clr) begin
         state_d = IDLE;
         hold_d  = '0;
         out_d   = '0;
         vld_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               // Loading from IDLE does not wait for en.
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  out_d    = onehot_decode(fifo_head);
                  vld_d    = 1'b1;
                  hold_d   = HOLD_RELOAD;
                  state_d  = SHOW;
               end
            end
            SHOW: begin
               if (en) begin
                  if (hold_q != '0) begin
                     hold_d = hold_q - HC_W'(1);
                  end else if (!fifo_empty) begin
                     // Back-to-back: next code replaces current on the same edge.
                     fifo_pop = 1'b1;
                     out_d    = onehot_decode(fifo_head);
                     hold_d   = HOLD_RELOAD;
                  end else begin
                     out_d   = '0;
                     vld_d   = 1'b0;
                     state_d = IDLE;
                  end
               end
            end
            default: begin
               state_d = IDLE;
               hold_d  = '0;
               out_d   = '0;
               vld_d   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         hold_q  <= '0;
         out_q   <= '0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         out_q   <= out_d;
         vld_q   <= vld_d;
      end
   end

endmodule
